// File: rtl/uart_psram_cmd_if.sv
// Bundle of the UART byte stream, PSRAM request bus and debug probe signals
// shared by the host command decoder and its neighbours.
interface uart_psram_cmd_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  read_write;
  logic [22:0] address;
  logic [15:0] data_in;
  logic        mem_ack;
  logic        mem_done;
  logic [15:0] data_out;
  logic        err;
  logic        overrun;
  logic [3:0]  process;

  // The command decoder sits on the slave side.
  modport slave (
    input  rx_data, rx_valid, tx_ready, mem_ack, mem_done, data_out,
    output tx_data, tx_valid, read_write, address, data_in, err, overrun, process
  );

  modport master (
    output rx_data, rx_valid, tx_ready, mem_ack, mem_done, data_out,
    input  tx_data, tx_valid, read_write, address, data_in, err, overrun, process
  );
endinterface

// File: rtl/uart_psram_cmd.sv
// Host command decoder: parses 'W'/'R' frames from the UART RX stream, issues one
// PSRAM access per frame and returns 'K', the read word, or 'E' over UART TX.
module uart_psram_cmd #(
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  uart_psram_cmd_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_REQ  = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_byte_cnt;
  logic             r_is_write;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic [7:0]       r_resp_lo;
  logic             r_resp_two;
  logic [1:0]       r_rw;
  logic [22:0]      r_address;
  logic [15:0]      r_data_in;
  logic             r_err;
  logic             r_overrun;

  logic w_timeout;
  logic w_busy;
  logic w_cmd_ok;
  logic w_tx_fire;
  logic w_shifting;

  assign w_timeout  = (r_cnt == CNT_MAX);
  assign w_busy     = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_RESP);
  assign w_cmd_ok   = (bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ);
  assign w_tx_fire  = r_tx_valid && bus.tx_ready;
  assign w_shifting = (r_state == ST_ADDR) || (r_state == ST_DATA);

  // An arriving byte always beats a timeout that expires in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          w_state_nxt = w_cmd_ok ? ST_ADDR : ST_RESP;
        end
      end
      ST_ADDR: begin
        if (bus.rx_valid) begin
          if (r_byte_cnt == 2'd2) begin
            w_state_nxt = r_is_write ? ST_DATA : ST_REQ;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bus.rx_valid) begin
          if (r_byte_cnt == 2'd1) begin
            w_state_nxt = ST_REQ;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_ack) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_done || w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_tx_fire && !r_resp_two) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bytes dropped while busy do not restart the PSRAM completion timer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_byte_cnt <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt      <= '0;
        r_byte_cnt <= 2'd0;
      end else begin
        if (w_shifting && bus.rx_valid) begin
          r_cnt      <= '0;
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end else if ((w_shifting || (r_state == ST_WAIT)) && !w_timeout) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_is_write <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_resp_lo  <= 8'h00;
      r_resp_two <= 1'b0;
      r_rw       <= 2'b00;
      r_address  <= '0;
      r_data_in  <= '0;
      r_err      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_overrun <= bus.rx_valid && w_busy;
      case (r_state)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            if (w_cmd_ok) begin
              r_is_write <= (bus.rx_data == CMD_WRITE);
            end else begin
              r_err      <= 1'b1;
              r_tx_data  <= RSP_ERR;
              r_tx_valid <= 1'b1;
              r_resp_two <= 1'b0;
            end
          end
        end
        ST_ADDR: begin
          // Shifting a 23-bit register three times naturally discards A2 bit 7.
          if (bus.rx_valid) begin
            r_address <= {r_address[14:0], bus.rx_data};
            if ((r_byte_cnt == 2'd2) && !r_is_write) begin
              r_rw <= 2'b01;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        ST_DATA: begin
          if (bus.rx_valid) begin
            r_data_in <= {r_data_in[7:0], bus.rx_data};
            if (r_byte_cnt == 2'd1) begin
              r_rw <= 2'b10;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            r_rw <= 2'b00;
          end
        end
        ST_WAIT: begin
          if (bus.mem_done) begin
            r_tx_valid <= 1'b1;
            if (r_is_write) begin
              r_tx_data  <= RSP_OK;
              r_resp_two <= 1'b0;
            end else begin
              r_tx_data  <= bus.data_out[15:8];
              r_resp_lo  <= bus.data_out[7:0];
              r_resp_two <= 1'b1;
            end
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_tx_data  <= RSP_ERR;
            r_tx_valid <= 1'b1;
            r_resp_two <= 1'b0;
          end
        end
        ST_RESP: begin
          if (w_tx_fire) begin
            if (r_resp_two) begin
              r_tx_data  <= r_resp_lo;
              r_resp_two <= 1'b0;
            end else begin
              r_tx_data  <= 8'h00;
              r_tx_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_rw       <= 2'b00;
        end
      endcase
    end
  end

  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.read_write = r_rw;
  assign bus.address    = r_address;
  assign bus.data_in    = r_data_in;
  assign bus.err        = r_err;
  assign bus.overrun    = r_overrun;
  assign bus.process    = {1'b0, r_state};

endmodule

// File: tb/tb_uart_psram_cmd.sv
// Directed bench for uart_psram_cmd: a table of complete frames plus hand-written
// sequences for invalid bytes, timeouts, overrun and asynchronous reset.
module tb_uart_psram_cmd;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [47:0] frame;
    int          nFrame;
    logic [15:0] rdata;
    int          ackDelay;
    int          doneDelay;
    bit          toggleReady;
    logic [1:0]  expRw;
    logic [22:0] expAddr;
    logic [15:0] expData;
    logic [15:0] expTx;
    int          nTx;
  } vector_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int checks = 0;
  int fails  = 0;
  vector_t vecs[5];
  vector_t extra;

  uart_psram_cmd_if bus();

  uart_psram_cmd #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rstN),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  function automatic logic [3:0] procAfterByte(input int idx, input bit isWrite);
    if (idx < 3) return 4'd1;
    if (idx == 3) return isWrite ? 4'd2 : 4'd3;
    if (idx == 4) return 4'd2;
    return 4'd3;
  endfunction

  task automatic applyStimulus(input vector_t v, input string tag);
    bit isWrite;
    logic [7:0] expByte;
    isWrite = (v.frame[47:40] == 8'h57);
    for (int i = 0; i < v.nFrame; i++) begin
      sendByte(v.frame[47 - 8*i -: 8]);
      checkOutput({tag, ".process"}, 32'(bus.process), 32'(procAfterByte(i, isWrite)));
    end
    checkOutput({tag, ".rw"}, 32'(bus.read_write), 32'(v.expRw));
    checkOutput({tag, ".addr"}, 32'(bus.address), 32'(v.expAddr));
    checkOutput({tag, ".dataIn"}, 32'(bus.data_in), 32'(v.expData));
    repeat (v.ackDelay) tick();
    checkOutput({tag, ".rwHeld"}, 32'(bus.read_write), 32'(v.expRw));
    checkOutput({tag, ".dataHeld"}, 32'(bus.data_in), 32'(v.expData));
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput({tag, ".rwAfterAck"}, 32'(bus.read_write), 32'(0));
    checkOutput({tag, ".processWait"}, 32'(bus.process), 32'(4));
    repeat (v.doneDelay) tick();
    bus.data_out = v.rdata;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    bus.data_out = 16'h0000;
    checkOutput({tag, ".processResp"}, 32'(bus.process), 32'(5));
    for (int k = 0; k < v.nTx; k++) begin
      expByte = (k == 0 && v.nTx == 2) ? v.expTx[15:8] : v.expTx[7:0];
      checkOutput({tag, ".txValid"}, 32'(bus.tx_valid), 32'(1));
      checkOutput({tag, ".txData"}, 32'(bus.tx_data), 32'(expByte));
      if (v.toggleReady) begin
        bus.tx_ready = 1'b0;
        tick();
        checkOutput({tag, ".txHoldData"}, 32'(bus.tx_data), 32'(expByte));
        checkOutput({tag, ".txHoldValid"}, 32'(bus.tx_valid), 32'(1));
      end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
    end
    checkOutput({tag, ".txDone"}, 32'(bus.tx_valid), 32'(0));
    checkOutput({tag, ".processIdle"}, 32'(bus.process), 32'(0));
  endtask

  initial begin
    int n;
    bit sawTx;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_done = 1'b0;
    bus.data_out = 16'h0000;

    vecs[0] = '{48'h5701_2345_BEEF, 6, 16'h0000, 2, 5, 1'b0, 2'b10, 23'h012345, 16'hBEEF, 16'h004B, 1};
    vecs[1] = '{48'h52FF_0010_0000, 4, 16'hA55A, 1, 3, 1'b1, 2'b01, 23'h7F0010, 16'hBEEF, 16'hA55A, 2};
    vecs[2] = '{48'h5780_0001_1234, 6, 16'h0000, 0, 0, 1'b0, 2'b10, 23'h000001, 16'h1234, 16'h004B, 1};
    vecs[3] = '{48'h527F_FFFF_0000, 4, 16'h0001, 3, 1, 1'b1, 2'b01, 23'h7FFFFF, 16'h1234, 16'h0001, 2};
    vecs[4] = '{48'h5200_0000_0000, 4, 16'hFFFF, 1, 2, 1'b0, 2'b01, 23'h000000, 16'h1234, 16'hFFFF, 2};

    #12;
    checkOutput("resetProcess", 32'(bus.process), 32'(0));
    checkOutput("resetTxValid", 32'(bus.tx_valid), 32'(0));
    checkOutput("resetTxData", 32'(bus.tx_data), 32'(0));
    checkOutput("resetRw", 32'(bus.read_write), 32'(0));
    checkOutput("resetAddr", 32'(bus.address), 32'(0));
    checkOutput("resetDataIn", 32'(bus.data_in), 32'(0));
    checkOutput("resetErr", 32'(bus.err), 32'(0));
    checkOutput("resetOverrun", 32'(bus.overrun), 32'(0));
    rstN = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Unknown command byte answers 'E' without touching PSRAM.
    sendByte(8'h41);
    checkOutput("badCmdErr", 32'(bus.err), 32'(1));
    checkOutput("badCmdProcess", 32'(bus.process), 32'(5));
    checkOutput("badCmdTxValid", 32'(bus.tx_valid), 32'(1));
    checkOutput("badCmdTxData", 32'(bus.tx_data), 32'(8'h45));
    tick();
    checkOutput("badCmdErrPulse", 32'(bus.err), 32'(0));
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    checkOutput("badCmdTxDone", 32'(bus.tx_valid), 32'(0));
    checkOutput("badCmdIdle", 32'(bus.process), 32'(0));

    // Stalled frame: err exactly TIMEOUT cycles after the last byte, no reply.
    sendByte(8'h52);
    sendByte(8'h00);
    n = 0;
    sawTx = 1'b0;
    while (!bus.err && n < 40) begin
      tick();
      n++;
      if (bus.tx_valid) sawTx = 1'b1;
    end
    checkOutput("interByteTimeoutCycles", 32'(n), 32'(TIMEOUT));
    checkOutput("interByteTimeoutIdle", 32'(bus.process), 32'(0));
    checkOutput("interByteTimeoutNoTx", 32'(sawTx), 32'(0));
    extra = '{48'h5212_3456_0000, 4, 16'hC3C3, 1, 1, 1'b0, 2'b01, 23'h123456, 16'h1234, 16'hC3C3, 2};
    applyStimulus(extra, "afterTimeout");

    // Overrun in WAIT, mem_done coincident with mem_ack ignored, then PSRAM timeout.
    sendByte(8'h57); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h02); sendByte(8'hCA); sendByte(8'hFE);
    checkOutput("ovrRw", 32'(bus.read_write), 32'(2));
    bus.mem_ack  = 1'b1;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_ack  = 1'b0;
    bus.mem_done = 1'b0;
    checkOutput("ackDoneSameCycle", 32'(bus.process), 32'(4));
    n = 0;
    sendByte(8'h52);
    n++;
    checkOutput("overrunPulse", 32'(bus.overrun), 32'(1));
    checkOutput("overrunState", 32'(bus.process), 32'(4));
    tick();
    n++;
    checkOutput("overrunPulseEnd", 32'(bus.overrun), 32'(0));
    while (!bus.err && n < 40) begin
      tick();
      n++;
    end
    checkOutput("memTimeoutCycles", 32'(n), 32'(TIMEOUT));
    checkOutput("memTimeoutTxValid", 32'(bus.tx_valid), 32'(1));
    checkOutput("memTimeoutTxData", 32'(bus.tx_data), 32'(8'h45));
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    checkOutput("memTimeoutTxDone", 32'(bus.tx_valid), 32'(0));

    // Asynchronous reset in the middle of a two-byte read response.
    sendByte(8'h52); sendByte(8'h00); sendByte(8'h00); sendByte(8'h08);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack  = 1'b0;
    bus.data_out = 16'h1357;
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    bus.data_out = 16'h0000;
    checkOutput("rstFirstByte", 32'(bus.tx_data), 32'(8'h13));
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    checkOutput("rstSecondByte", 32'(bus.tx_data), 32'(8'h57));
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstTxValid", 32'(bus.tx_valid), 32'(0));
    checkOutput("asyncRstRw", 32'(bus.read_write), 32'(0));
    checkOutput("asyncRstProcess", 32'(bus.process), 32'(0));
    checkOutput("asyncRstAddr", 32'(bus.address), 32'(0));
    #2;
    rstN = 1'b1;
    tick();
    extra = '{48'h5700_0009_55AA, 6, 16'h0000, 1, 1, 1'b0, 2'b10, 23'h000009, 16'h55AA, 16'h004B, 1};
    applyStimulus(extra, "afterReset");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
